alarm_controller: RTL and testbench

ALARM_CONTROLLER -- requirements
Module: alarm_controller

---
 rtl/alarm_controller.sv | 122 ++++++++++++
 tb/tb_alarm_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm controller: Moore FSM that rings, snoozes and stops one alarm event.
// The comparator match and both buttons act only on their rising edges.
module alarm_controller #(
    parameter int SNOOZE_MIN   = 9,
    parameter int RING_TIMEOUT = 5,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       AA,
    input  logic       ALARM_EN,
    input  logic       MIN_TICK,
    input  logic       SNOOZE,
    input  logic       STOP,
    output logic       BUZZ,
    output logic       SNOOZING,
    output logic [1:0] SNOOZE_CNT,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RING    = 2'b01,
        S_SNOOZE  = 2'b10,
        S_INVALID = 2'b11
    } state_t;

    localparam logic [4:0] RING_LIMIT   = 5'(RING_TIMEOUT);
    localparam logic [4:0] SNOOZE_LIMIT = 5'(SNOOZE_MIN);
    localparam logic [1:0] SNOOZE_MAX   = 2'(MAX_SNOOZE);

    state_t     state;
    state_t     state_next;
    logic [3:0] timer;
    logic [3:0] timer_next;
    logic [1:0] snooze_cnt;
    logic [1:0] snooze_cnt_next;
    logic       aa_prev;
    logic       snooze_prev;
    logic       stop_prev;
    logic       aa_rise;
    logic       snooze_rise;
    logic       stop_rise;
    logic [4:0] timer_inc;

    assign aa_rise     = AA & ~aa_prev;
    assign snooze_rise = SNOOZE & ~snooze_prev;
    assign stop_rise   = STOP & ~stop_prev;
    // One bit wider so a 4-bit timer at 15 cannot wrap before the compare.
    assign timer_inc   = {1'b0, timer} + 5'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            timer       <= '0;
            snooze_cnt  <= '0;
            aa_prev     <= 1'b0;
            snooze_prev <= 1'b0;
            stop_prev   <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            snooze_cnt  <= snooze_cnt_next;
            aa_prev     <= AA;
            snooze_prev <= SNOOZE;
            stop_prev   <= STOP;
        end
    end

    // Event priority: enable drop, stop, snooze, then minute timer expiry.
    always_comb begin
        state_next      = state;
        timer_next      = timer;
        snooze_cnt_next = snooze_cnt;
        case (state)
            S_IDLE: begin
                if (aa_rise && ALARM_EN) begin
                    state_next      = S_RING;
                    snooze_cnt_next = '0;
                end
            end
            S_RING: begin
                if (!ALARM_EN || stop_rise) begin
                    state_next = S_IDLE;
                end else if (snooze_rise && (snooze_cnt < SNOOZE_MAX)) begin
                    state_next      = S_SNOOZE;
                    snooze_cnt_next = snooze_cnt + 2'd1;
                end else if (MIN_TICK) begin
                    if (timer_inc == RING_LIMIT) begin
                        state_next = S_IDLE;
                    end else begin
                        timer_next = timer_inc[3:0];
                    end
                end
            end
            S_SNOOZE: begin
                if (!ALARM_EN || stop_rise) begin
                    state_next = S_IDLE;
                end else if (MIN_TICK) begin
                    if (timer_inc == SNOOZE_LIMIT) begin
                        state_next = S_RING;
                    end else begin
                        timer_next = timer_inc[3:0];
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Each state starts its minute count afresh; the tick that caused the move is dropped.
        if (state_next != state) begin
            timer_next = '0;
        end
    end

    assign BUZZ       = (state == S_RING);
    assign SNOOZING   = (state == S_SNOOZE);
    assign SNOOZE_CNT = snooze_cnt;
    assign STATE      = state;

endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: fixed vector table, reset corner cases, then random
// stimulus checked against a countdown-based reference model.
module tb_alarm_controller;

    localparam int SNOOZE_MIN   = 2;
    localparam int RING_TIMEOUT = 3;
    localparam int MAX_SNOOZE   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       aa;
    logic       alarm_en;
    logic       min_tick;
    logic       snooze;
    logic       stop;
    logic       buzz;
    logic       snoozing;
    logic [1:0] snooze_cnt;
    logic [1:0] state;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic aa;
        logic en;
        logic tick;
        logic snz;
        logic stp;
        int   exp_state;
        int   exp_cnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model: 0 idle, 1 ringing, 2 snoozing; minutes_left counts down to the next timeout.
    int m_state;
    int m_cnt;
    int m_minutes_left;
    bit m_aa;
    bit m_snz;
    bit m_stop;

    alarm_controller #(
        .SNOOZE_MIN  (SNOOZE_MIN),
        .RING_TIMEOUT(RING_TIMEOUT),
        .MAX_SNOOZE  (MAX_SNOOZE)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .AA        (aa),
        .ALARM_EN  (alarm_en),
        .MIN_TICK  (min_tick),
        .SNOOZE    (snooze),
        .STOP      (stop),
        .BUZZ      (buzz),
        .SNOOZING  (snoozing),
        .SNOOZE_CNT(snooze_cnt),
        .STATE     (state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state        = 0;
        m_cnt          = 0;
        m_minutes_left = 0;
        m_aa           = 0;
        m_snz          = 0;
        m_stop         = 0;
    endtask

    task automatic model_step(input bit a, input bit e, input bit t, input bit s, input bit p);
        bit alarm_fired  = a && !m_aa;
        bit snooze_press = s && !m_snz;
        bit stop_press   = p && !m_stop;
        if (m_state == 0) begin
            if (alarm_fired && e) begin
                m_state        = 1;
                m_cnt          = 0;
                m_minutes_left = RING_TIMEOUT;
            end
        end else if (!e || stop_press) begin
            m_state = 0;
        end else if (m_state == 1 && snooze_press && m_cnt < MAX_SNOOZE) begin
            m_state        = 2;
            m_cnt          = m_cnt + 1;
            m_minutes_left = SNOOZE_MIN;
        end else if (t) begin
            m_minutes_left = m_minutes_left - 1;
            if (m_minutes_left == 0) begin
                if (m_state == 1) begin
                    m_state = 0;
                end else begin
                    m_state        = 1;
                    m_minutes_left = RING_TIMEOUT;
                end
            end
        end
        m_aa   = a;
        m_snz  = s;
        m_stop = p;
    endtask

    task automatic applyStimulus(input bit a, input bit e, input bit t, input bit s, input bit p);
        aa       = a;
        alarm_en = e;
        min_tick = t;
        snooze   = s;
        stop     = p;
        model_step(a, e, t, s, p);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int exp_state, input int exp_cnt);
        logic [1:0] es;
        logic [1:0] ec;
        logic       eb;
        logic       esn;
        es  = 2'(exp_state);
        ec  = 2'(exp_cnt);
        eb  = (exp_state == 1);
        esn = (exp_state == 2);
        compared++;
        if (state !== es || buzz !== eb || snoozing !== esn || snooze_cnt !== ec) begin
            mismatched++;
            $display("[TB] FAIL %s: got state=%0d buzz=%0b snoozing=%0b cnt=%0d, expected state=%0d buzz=%0b snoozing=%0b cnt=%0d",
                     name, state, buzz, snoozing, snooze_cnt, es, eb, esn, ec);
        end
    endtask

    task automatic add(input bit a, input bit e, input bit t, input bit s, input bit p,
                       input int st, input int cnt);
        vec_t v;
        v.aa = a; v.en = e; v.tick = t; v.snz = s; v.stp = p;
        v.exp_state = st;
        v.exp_cnt   = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ra, re, rt, rs, rp;

        //  aa en tk sz sp  state cnt
        add(0, 1, 0, 0, 0,  0, 0);
        add(1, 1, 0, 0, 0,  1, 0);
        add(1, 1, 1, 0, 0,  1, 0);
        add(1, 1, 0, 0, 0,  1, 0);
        add(1, 1, 1, 0, 0,  1, 0);
        add(1, 1, 1, 0, 0,  0, 0);
        add(1, 1, 0, 0, 0,  0, 0);
        add(0, 1, 0, 0, 0,  0, 0);
        add(1, 1, 0, 0, 0,  1, 0);
        add(1, 1, 0, 1, 0,  2, 1);
        add(1, 1, 1, 0, 0,  2, 1);
        add(1, 1, 1, 0, 0,  1, 1);
        add(1, 1, 0, 1, 0,  1, 1);
        add(1, 1, 0, 0, 0,  1, 1);
        add(1, 1, 1, 0, 0,  1, 1);
        add(1, 1, 1, 0, 0,  1, 1);
        add(1, 1, 1, 0, 0,  0, 1);
        add(0, 1, 0, 0, 0,  0, 1);
        add(1, 1, 0, 0, 0,  1, 0);
        add(1, 1, 0, 1, 1,  0, 0);
        add(0, 1, 0, 0, 0,  0, 0);
        add(1, 1, 0, 0, 0,  1, 0);
        add(1, 1, 0, 1, 0,  2, 1);
        add(1, 1, 0, 1, 0,  2, 1);
        add(1, 0, 0, 1, 0,  0, 1);
        add(0, 0, 0, 1, 0,  0, 1);
        add(1, 0, 0, 0, 0,  0, 1);
        add(1, 1, 0, 0, 0,  0, 1);
        add(0, 1, 0, 0, 0,  0, 1);
        add(1, 1, 0, 0, 0,  1, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 1, 0, 2, 1);
        add(1, 1, 0, 0, 0,  2, 1);
        add(1, 1, 0, 1, 0,  2, 1);
        add(1, 1, 0, 0, 1,  0, 1);
        add(1, 1, 0, 0, 1,  0, 1);

        reset = 1'b1;
        aa = 0; alarm_en = 1; min_tick = 0; snooze = 0; stop = 0;
        model_reset();
        #12;
        checkOutput("reset_state", 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].aa, vecs[i].en, vecs[i].tick, vecs[i].snz, vecs[i].stp);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_cnt);
        end

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("ring_before_reset", 1, 0);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("reset_mid_ring", 0, 0);
        #1;
        reset = 1'b0;
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("aa_high_after_reset", 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("snooze_before_reset", 2, 1);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("reset_mid_snooze", 0, 0);
        #1;
        reset = 1'b0;
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("rering_after_snooze_reset", 1, 0);

        ra = 1; re = 1; rt = 0; rs = 0; rp = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) ra = !ra;
            re = ($urandom_range(0, 19) != 0);
            rt = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) rs = !rs;
            if ($urandom_range(0, 9) == 0) rp = !rp;
            applyStimulus(ra, re, rt, rs, rp);
            checkOutput("random", m_state, m_cnt);
            if ($urandom_range(0, 149) == 0) begin
                #3;
                reset = 1'b1;
                model_reset();
                #1;
                checkOutput("random_reset", 0, 0);
                #1;
                reset = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
